// File: rtl/pipe_pkg.sv
// Shared types and default widths for the generic pipeline boundary stage.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 16;
   localparam int unsigned PIPE_CTRL_W = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occState_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One storage slot: data and ctrl with load enable; synchronous clear zeroes ctrl only.
module pipe_entry_reg #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] dData,
   input  logic [CTRL_W-1:0] dCtrl,
   output logic [DATA_W-1:0] qData,
   output logic [CTRL_W-1:0] qCtrl
);

   // Payload is never cleared; a squashed slot only needs its control neutralised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qData <= DATA_W'(0);
      end else if (load) begin
         qData <= dData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qCtrl <= CTRL_W'(0);
      end else if (clear) begin
         qCtrl <= CTRL_W'(0);
      end else if (load) begin
         qCtrl <= dCtrl;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline boundary with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W              = PIPE_DATA_W,
   parameter int unsigned CTRL_W              = PIPE_CTRL_W,
   parameter int unsigned ZERO_CTRL_ON_BUBBLE = 1
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int unsigned CNT_W               = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   occState_t         state, stateNxt;
   logic              inFire, outFire;
   logic              mainLoad, skidLoad, mainFromSkid;
   logic [DATA_W-1:0] mainData, skidData, mainDataD;
   logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainCtrlD;

   // Handshake signals decode the state register only, so ready never depends on out_ready.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign inFire    = in_valid & in_ready;
   assign outFire   = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= stateNxt;
      end
   end

   always_comb begin
      stateNxt     = state;
      mainLoad     = 1'b0;
      skidLoad     = 1'b0;
      mainFromSkid = 1'b0;
      if (flush) begin
         stateNxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (inFire) begin
                  stateNxt = ONE;
                  mainLoad = 1'b1;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  mainLoad = 1'b1;
               end else if (inFire) begin
                  stateNxt = FULL;
                  skidLoad = 1'b1;
               end else if (outFire) begin
                  stateNxt = EMPTY;
               end
            end
            FULL: begin
               if (outFire) begin
                  stateNxt     = ONE;
                  mainLoad     = 1'b1;
                  mainFromSkid = 1'b1;
               end
            end
            default: stateNxt = EMPTY;
         endcase
      end
   end

   assign mainDataD = mainFromSkid ? skidData : in_data;
   assign mainCtrlD = mainFromSkid ? skidCtrl : in_ctrl;

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) mainEntry (
      .clk   (clk),
      .rst   (rst),
      .load  (mainLoad),
      .clear (flush),
      .dData (mainDataD),
      .dCtrl (mainCtrlD),
      .qData (mainData),
      .qCtrl (mainCtrl)
   );

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skidEntry (
      .clk   (clk),
      .rst   (rst),
      .load  (skidLoad),
      .clear (flush),
      .dData (in_data),
      .dCtrl (in_ctrl),
      .qData (skidData),
      .qCtrl (skidCtrl)
   );

   assign out_data = mainData;
   // A drained main slot keeps its old ctrl; mask it so a bubble never carries write enables.
   assign out_ctrl = ((ZERO_CTRL_ON_BUBBLE != 0) && (state == EMPTY)) ? CTRL_W'(0) : mainCtrl;

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= CNT_W'(0);
         bubble_cnt <= CNT_W'(0);
      end else begin
         if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (!out_valid && !flush && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a queue-based FIFO model.
module tb_pipe_stage_buf;

   localparam int unsigned DW   = 16;
   localparam int unsigned CW   = 8;
   localparam int unsigned CNTW = 4;
   localparam int unsigned CMAX = (1 << CNTW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNTW-1:0] stall_cnt, bubble_cnt;
`endif

   int testCnt = 0;
   int failCnt = 0;

   logic [CW+DW-1:0] mq[$];
   int unsigned      mStall, mBubble;

   pipe_stage_buf #(
      .DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL_ON_BUBBLE(1)
`ifdef PIPE_STAGE_PERF_EN
      , .CNT_W(CNTW)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .flush     (flush)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt (stall_cnt)
      , .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutputs();
      logic [CW+DW-1:0] head;
      checkEq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      checkEq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         head = mq[0];
         checkEq("out_data", 32'(out_data), 32'(head[DW-1:0]));
         checkEq("out_ctrl", 32'(out_ctrl), 32'(head[CW+DW-1:DW]));
      end else begin
         checkEq("out_ctrl_bubble", 32'(out_ctrl), 32'(0));
      end
`ifdef PIPE_STAGE_PERF_EN
      checkEq("stall_cnt", 32'(stall_cnt), mStall);
      checkEq("bubble_cnt", 32'(bubble_cnt), mBubble);
`endif
   endtask

   // Drive one cycle of inputs (called at a negedge), advance the model, then check after the edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ord, input logic fl);
      bit inF, outF;
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ord;
      flush     = fl;
      inF  = v && (mq.size() < 2);
      outF = (mq.size() > 0) && ord;
      if ((mq.size() > 0) && !ord && (mStall < CMAX)) mStall++;
      if ((mq.size() == 0) && !fl && (mBubble < CMAX)) mBubble++;
      if (fl) begin
         mq.delete();
      end else begin
         if (outF) void'(mq.pop_front());
         if (inF) mq.push_back({c, d});
      end
      @(negedge clk);
      checkOutputs();
   endtask

   task automatic modelReset();
      mq.delete();
      mStall  = 0;
      mBubble = 0;
   endtask

   initial begin
      modelReset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hBEEF;
      in_ctrl   = 8'h5A;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkEq("rst_out_valid", 32'(out_valid), 32'(0));
      checkEq("rst_out_ctrl", 32'(out_ctrl), 32'(0));
      checkEq("rst_out_data", 32'(out_data), 32'(0));
      checkEq("rst_in_ready", 32'(in_ready), 32'(1));
      rst = 1'b0;

      // BEEF captured on the first edge after release
      step(1'b1, 16'hBEEF, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);

      // Back-to-back stream at full rate
      for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(8'h10 + i), 1'b1, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);

      // Backpressure into FULL, then in-order drain
      step(1'b1, 16'h00A0, 8'h0A, 1'b0, 1'b0);
      step(1'b1, 16'h00B0, 8'h0B, 1'b0, 1'b0);
      step(1'b1, 16'h00EE, 8'h0E, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);

      // Flush from FULL discards the concurrent input
      step(1'b1, 16'h0011, 8'h31, 1'b0, 1'b0);
      step(1'b1, 16'h0022, 8'h32, 1'b0, 1'b0);
      step(1'b1, 16'h00C0, 8'h3C, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);

      // Single slot with all ctrl bits set, then a bubble
      step(1'b1, 16'h1234, 8'hFF, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 8'h00, 1'b1, 1'b0);

      // Long stall to saturate the stall counter
      step(1'b1, 16'h5555, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in mid-cycle wipes everything
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkEq("arst_out_valid", 32'(out_valid), 32'(0));
      checkEq("arst_in_ready", 32'(in_ready), 32'(1));
      checkEq("arst_out_ctrl", 32'(out_ctrl), 32'(0));
`ifdef PIPE_STAGE_PERF_EN
      checkEq("arst_stall_cnt", 32'(stall_cnt), 32'(0));
`endif
      @(negedge clk);
      rst = 1'b0;

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, DW'($urandom), CW'($urandom),
              ($urandom % 3) != 0, ($urandom % 16) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
